// File: rtl/hc74_pkg.sv
// hc74 family shared definitions.
// Register width and pin-synchronizer reset levels.
package hc74_pkg;

  localparam int SR_WIDTH = 8;

  typedef logic [SR_WIDTH-1:0] sr_t;

  // Idle level of sampled pins after reset:
  // clocks/MR# idle high, DS idles low.
  localparam logic PIN_RST = 1'b1;
  localparam logic DS_RST  = 1'b0;

endpackage

// File: rtl/hc_pin_sync.sv
// N-flop pin synchronizer, N=0 is a wire.
// clk, rst_n (sync, active low), d pin in, q synced out.
module hc_pin_sync #(
  parameter int   N       = 0,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (N == 0) begin : g_pass
      logic sync_unused;
      assign sync_unused = clk ^ rst_n;
      assign q = d;
    end else begin : g_chain
      logic [N-1:0] chain;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chain <= {N{RST_VAL}};
        end else begin
          chain <= (chain << 1) | N'(d);
        end
      end
      assign q = chain[N-1];
    end
  endgenerate

endmodule

// File: rtl/hc595_clk.sv
// Clock-synchronous 74HC595 SIPO + storage register.
// p14 DS, p11 SH_CP, p12 ST_CP, p10 MR#, p13 OE#;
// p15,p1..p7 Q0..Q7, p9 Q7', q_oe = ~OE#.
module hc595_clk
  import hc74_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p14,
  input  logic p11,
  input  logic p12,
  input  logic p10,
  input  logic p13,
  output logic p15,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p5,
  output logic p6,
  output logic p7,
  output logic p9,
  output logic q_oe
);

  logic ds_s;
  logic sh_s;
  logic st_s;
  logic mr_s;

  hc_pin_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (DS_RST)
  ) u_ds (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (p14),
    .q     (ds_s)
  );

  hc_pin_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (PIN_RST)
  ) u_sh (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (p11),
    .q     (sh_s)
  );

  hc_pin_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (PIN_RST)
  ) u_st (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (p12),
    .q     (st_s)
  );

  hc_pin_sync #(
    .N       (SYNC_STAGES),
    .RST_VAL (PIN_RST)
  ) u_mr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (p10),
    .q     (mr_s)
  );

  sr_t  sr;
  sr_t  st;
  logic prev_sh;
  logic prev_st;
  logic sh_rise;
  logic st_rise;

  assign sh_rise = sh_s & ~prev_sh;
  assign st_rise = st_s & ~prev_st;

  // prev_* reset high so a pin held high across
  // reset release is not taken as a fresh edge.
  // st always captures the pre-edge sr, giving the
  // one-step lag of tied SH_CP/ST_CP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      st      <= '0;
      prev_sh <= 1'b1;
      prev_st <= 1'b1;
    end else begin
      prev_sh <= sh_s;
      prev_st <= st_s;
      if (st_rise) begin
        st <= sr;
      end
      if (!mr_s) begin
        sr <= '0;
      end else if (sh_rise) begin
        sr <= {sr[SR_WIDTH-2:0], ds_s};
      end
    end
  end

  assign p15  = st[0];
  assign p1   = st[1];
  assign p2   = st[2];
  assign p3   = st[3];
  assign p4   = st[4];
  assign p5   = st[5];
  assign p6   = st[6];
  assign p7   = st[7];
  assign p9   = sr[SR_WIDTH-1];
  assign q_oe = ~p13;

endmodule

// File: tb/tb_hc595_clk.sv
// Directed bench for hc595_clk, SYNC_STAGES 0 and 2.
// Both instances share pins; the N=2 copy lags by 2 clk.
module tb_hc595_clk;

  logic clk = 1'b0;
  logic rst_n;
  logic p14, p11, p12, p10, p13;

  wire [7:0] qa;
  wire [7:0] qb;
  wire       p9a, p9b, oea, oeb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hc595_clk #(.SYNC_STAGES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .p14   (p14),
    .p11   (p11),
    .p12   (p12),
    .p10   (p10),
    .p13   (p13),
    .p15   (qa[0]),
    .p1    (qa[1]),
    .p2    (qa[2]),
    .p3    (qa[3]),
    .p4    (qa[4]),
    .p5    (qa[5]),
    .p6    (qa[6]),
    .p7    (qa[7]),
    .p9    (p9a),
    .q_oe  (oea)
  );

  hc595_clk #(.SYNC_STAGES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .p14   (p14),
    .p11   (p11),
    .p12   (p12),
    .p10   (p10),
    .p13   (p13),
    .p15   (qb[0]),
    .p1    (qb[1]),
    .p2    (qb[2]),
    .p3    (qb[3]),
    .p4    (qb[4]),
    .p5    (qb[5]),
    .p6    (qb[6]),
    .p7    (qb[7]),
    .p9    (p9b),
    .q_oe  (oeb)
  );

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge,
  // so outputs are read well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sh_pulse(input logic d);
    p14 = d;
    p11 = 1'b1;
    tick();
    p11 = 1'b0;
    tick();
  endtask

  task automatic st_pulse();
    p12 = 1'b1;
    tick();
    p12 = 1'b0;
    tick();
  endtask

  task automatic load_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      sh_pulse(v[i]);
    end
  endtask

  logic [7:0] pat;
  logic [7:0] m_sr;
  logic [7:0] piso;

  initial begin
    rst_n = 1'b0;
    p14 = 1'b0;
    p11 = 1'b0;
    p12 = 1'b0;
    p10 = 1'b1;
    p13 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_q", qa, 8'h00);
    check("rst_p9", {7'd0, p9a}, 8'h00);
    check("rst_oe", {7'd0, oea}, 8'h01);

    // 0xA5 MSB first; p9 tracks bit 7 of a model sr
    pat  = 8'hA5;
    m_sr = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p14 = pat[i];
      p11 = 1'b1;
      tick();
      m_sr = {m_sr[6:0], pat[i]};
      check($sformatf("a5_p9_%0d", 7 - i),
            {7'd0, p9a}, {7'd0, m_sr[7]});
      p11 = 1'b0;
      tick();
    end
    st_pulse();
    check("a5_q", qa, 8'hA5);

    // shifting zeros now presents 1,0,1,0,0,1,0,1 on p9
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("a5_out_%0d", 7 - i),
            {7'd0, p9a}, {7'd0, pat[i]});
      sh_pulse(1'b0);
    end
    check("a5_hold", qa, 8'hA5);

    // tied SH_CP/ST_CP: storage lags one shift
    for (int i = 0; i < 8; i++) begin
      p14 = 1'b1;
      p11 = 1'b1;
      p12 = 1'b1;
      tick();
      p11 = 1'b0;
      p12 = 1'b0;
      tick();
    end
    check("tied_8", qa, 8'h7F);
    p11 = 1'b1;
    p12 = 1'b1;
    tick();
    p11 = 1'b0;
    p12 = 1'b0;
    tick();
    check("tied_9", qa, 8'hFF);

    // MR# clears sr only
    load_byte(8'h3C);
    st_pulse();
    check("mr_load", qa, 8'h3C);
    load_byte(8'hFF);
    check("mr_pre_p9", {7'd0, p9a}, 8'h01);
    p10 = 1'b0;
    tick();
    tick();
    p10 = 1'b1;
    tick();
    check("mr_p9", {7'd0, p9a}, 8'h00);
    check("mr_q", qa, 8'h3C);
    st_pulse();
    check("mr_st", qa, 8'h00);

    // upstream PISO shares the pin clock; DS is its
    // pre-edge output, updated after each rising edge
    piso = 8'h96;
    p14  = piso[7];
    for (int i = 0; i < 8; i++) begin
      p11 = 1'b1;
      tick();
      piso = {piso[6:0], 1'b0};
      p14  = piso[7];
      p11  = 1'b0;
      tick();
    end
    p12 = 1'b1;
    tick();
    check("piso_q0", qa, 8'h96);
    check("piso_q2_k", qb, 8'h00);
    p12 = 1'b0;
    tick();
    check("piso_q2_k1", qb, 8'h00);
    tick();
    check("piso_q2_k2", qb, 8'h96);

    // reset mid-byte with SH_CP held high
    for (int i = 0; i < 3; i++) begin
      sh_pulse(1'b1);
    end
    p14 = 1'b1;
    p11 = 1'b1;
    tick();
    check("mid_p9", {7'd0, p9a}, 8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_q", qa, 8'h00);
    tick();
    tick();
    st_pulse();
    check("mid_noedge", qa, 8'h00);
    p11 = 1'b0;
    tick();
    p11 = 1'b1;
    tick();
    p11 = 1'b0;
    tick();
    st_pulse();
    check("mid_edge", qa, 8'h01);

    p13 = 1'b1;
    #1;
    check("oe_off", {7'd0, oea}, 8'h00);
    check("oe_q", qa, 8'h01);
    p13 = 1'b0;
    #1;
    check("oe_on", {7'd0, oea}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
